// File: rtl/fir_serial_mac_if.sv
// fir_serial_mac_if: sample/coefficient handshake bundle for the serial-MAC FIR.
interface fir_serial_mac_if #(
    parameter int WIDTH  = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 8
);
    localparam int AW = $clog2(TAPS);
    logic signed [WIDTH-1:0]  sig_in;
    logic                     en_in;
    logic                     rdy_in;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic signed [WIDTH-1:0]  sig_out;
    logic                     en_out;
    modport master (
        output sig_in, en_in, coef_we, coef_addr, coef_data,
        input  rdy_in, sig_out, en_out
    );
    modport slave (
        input  sig_in, en_in, coef_we, coef_addr, coef_data,
        output rdy_in, sig_out, en_out
    );
endinterface

// File: rtl/fir_serial_mac.sv
// fir_serial_mac: time-multiplexed direct-form FIR, one MAC per tap per sample, rounded and saturated output.
`ifndef WIDTH
`define WIDTH 16
`endif
module fir_serial_mac #(
    parameter int WIDTH     = `WIDTH,
    parameter int COEF_W    = 16,
    parameter int TAPS      = 8,
    parameter int OUT_SHIFT = 15
) (
    input logic              clk,
    input logic              rst_n,
    fir_serial_mac_if.slave  bus
);
    localparam int AW    = $clog2(TAPS);
    localparam int PW    = WIDTH + COEF_W;
    localparam int ACC_W = PW + AW;
    localparam logic [AW-1:0] LAST = AW'(TAPS - 1);
    localparam logic signed [ACC_W:0] ONE  = {{ACC_W{1'b0}}, 1'b1};
    localparam logic signed [ACC_W:0] RND  = OUT_SHIFT > 0 ? ONE <<< (OUT_SHIFT > 0 ? OUT_SHIFT - 1 : 0) : '0;
    localparam logic signed [ACC_W:0] MAXV = {{(ACC_W - WIDTH + 2){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV = ~MAXV;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                   state_q, state_d;
    logic [AW-1:0]            idx_q, idx_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [WIDTH-1:0]  x_q [TAPS];
    logic signed [WIDTH-1:0]  x_d [TAPS];
    logic signed [COEF_W-1:0] c_q [TAPS];
    logic signed [COEF_W-1:0] c_d [TAPS];
    logic signed [WIDTH-1:0]  sig_out_q, sig_out_d;
    logic                     en_out_q, en_out_d;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W:0]    rnd, shr;
    logic signed [WIDTH-1:0]  sat;
    logic                     coef_ok;

    always_comb begin
        prod    = x_q[idx_q] * c_q[idx_q];
        rnd     = {acc_q[ACC_W-1], acc_q} + RND;
        shr     = rnd >>> OUT_SHIFT;
        sat     = shr > MAXV ? MAXV[WIDTH-1:0] : shr < MINV ? MINV[WIDTH-1:0] : shr[WIDTH-1:0];
        coef_ok = bus.coef_we && state_q == IDLE && {1'b0, bus.coef_addr} < (AW + 1)'(TAPS);
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        x_d       = x_q;
        c_d       = c_q;
        sig_out_d = sig_out_q;
        en_out_d  = 1'b0;
        // A coefficient written in the accepting cycle is visible to that sample's first MAC.
        if (coef_ok) c_d[bus.coef_addr] = bus.coef_data;
        case (state_q)
            IDLE: if (bus.en_in) begin
                x_d[0] = bus.sig_in;
                for (int k = 1; k < TAPS; k++) x_d[k] = x_q[k-1];
                acc_d   = '0;
                idx_d   = '0;
                state_d = MAC;
            end
            MAC: begin
                acc_d   = acc_q + {{AW{prod[PW-1]}}, prod};
                idx_d   = idx_q == LAST ? idx_q : idx_q + 1'b1;
                state_d = idx_q == LAST ? OUT : MAC;
            end
            OUT: begin
                sig_out_d = sat;
                en_out_d  = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            x_q       <= '{default: '0};
            c_q       <= '{default: '0};
            sig_out_q <= '0;
            en_out_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            x_q       <= x_d;
            c_q       <= c_d;
            sig_out_q <= sig_out_d;
            en_out_q  <= en_out_d;
        end
    end

    assign bus.rdy_in  = state_q == IDLE;
    assign bus.sig_out = sig_out_q;
    assign bus.en_out  = en_out_q;
endmodule

// File: tb/tb_fir_serial_mac.sv
// tb_fir_serial_mac: directed checks of impulse, handshake, saturation, rounding, reset and address range.
module tb_fir_serial_mac;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    logic signed [15:0] sig_in_v [3];
    logic               en_v     [3];
    logic               we_v     [3];
    logic [2:0]         addr_v   [3];
    logic signed [15:0] data_v   [3];
    logic signed [15:0] out_w    [3];
    logic               eo_w     [3];
    logic               rdy_w    [3];

    always #5 clk = ~clk;

    fir_serial_mac_if #(.WIDTH(16), .COEF_W(16), .TAPS(8)) ifa ();
    fir_serial_mac_if #(.WIDTH(16), .COEF_W(16), .TAPS(8)) ifb ();
    fir_serial_mac_if #(.WIDTH(16), .COEF_W(16), .TAPS(6)) ifc ();

    fir_serial_mac #(.WIDTH(16), .COEF_W(16), .TAPS(8), .OUT_SHIFT(0))  dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    fir_serial_mac #(.WIDTH(16), .COEF_W(16), .TAPS(8), .OUT_SHIFT(15)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    fir_serial_mac #(.WIDTH(16), .COEF_W(16), .TAPS(6), .OUT_SHIFT(0))  dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    assign ifa.sig_in = sig_in_v[0]; assign ifa.en_in = en_v[0]; assign ifa.coef_we = we_v[0];
    assign ifa.coef_addr = addr_v[0]; assign ifa.coef_data = data_v[0];
    assign ifb.sig_in = sig_in_v[1]; assign ifb.en_in = en_v[1]; assign ifb.coef_we = we_v[1];
    assign ifb.coef_addr = addr_v[1]; assign ifb.coef_data = data_v[1];
    assign ifc.sig_in = sig_in_v[2]; assign ifc.en_in = en_v[2]; assign ifc.coef_we = we_v[2];
    assign ifc.coef_addr = addr_v[2]; assign ifc.coef_data = data_v[2];
    assign out_w[0] = ifa.sig_out; assign eo_w[0] = ifa.en_out; assign rdy_w[0] = ifa.rdy_in;
    assign out_w[1] = ifb.sig_out; assign eo_w[1] = ifb.en_out; assign rdy_w[1] = ifb.rdy_in;
    assign out_w[2] = ifc.sig_out; assign eo_w[2] = ifc.en_out; assign rdy_w[2] = ifc.rdy_in;

    task automatic write_coef(input int s, input logic [2:0] a, input logic signed [15:0] d);
        @(negedge clk);
        we_v[s] = 1'b1; addr_v[s] = a; data_v[s] = d;
        @(negedge clk);
        we_v[s] = 1'b0;
    endtask

    // Accept one sample and wait for its result; optionally pulse coef_we in cycle we_at (0 = accept cycle).
    task automatic run_sample(input int s, input logic signed [15:0] v, input int we_at,
                              input logic [2:0] wa, input logic signed [15:0] wd,
                              output logic signed [15:0] y, output int lat, output int rdy_bad);
        int w;
        w = 0; y = 'x; lat = -1; rdy_bad = 0;
        @(negedge clk);
        while (!rdy_w[s] && w < 40) begin @(negedge clk); w++; end
        if (!rdy_w[s]) return;
        sig_in_v[s] = v; en_v[s] = 1'b1; addr_v[s] = wa; data_v[s] = wd; we_v[s] = (we_at == 0);
        @(negedge clk);
        en_v[s] = 1'b0; we_v[s] = 1'b0; lat = 1;
        while (!eo_w[s] && lat < 40) begin
            if (rdy_w[s]) rdy_bad++;
            we_v[s] = (we_at == lat);
            @(negedge clk);
            lat++;
        end
        we_v[s] = 1'b0;
        y = out_w[s];
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (out_w[s] !== 16'sd0 || eo_w[s] !== 1'b0 || rdy_w[s] !== 1'b1) begin
                failures++;
                $display("FAIL reset[%0d] sig_out=%0d en_out=%b rdy_in=%b want 0/0/1", s, out_w[s], eo_w[s], rdy_w[s]);
            end
        end
    endtask

    task automatic test_impulse();
        logic signed [15:0] y; int lat, rb;
        for (int k = 0; k < 8; k++) write_coef(0, 3'(k), 16'(k + 1));
        for (int i = 0; i < 8; i++) begin
            run_sample(0, i == 0 ? 16'sd1 : 16'sd0, -1, 3'd0, 16'sd0, y, lat, rb);
            checks++;
            if (y !== 16'(i + 1) || lat !== 10 || rb !== 0) begin
                failures++;
                $display("FAIL impulse[%0d] y=%0d lat=%0d rdy_early=%0d want y=%0d lat=10 rdy_early=0", i, y, lat, rb, i + 1);
            end
        end
    endtask

    task automatic test_handshake();
        logic signed [15:0] y; int lat, rb;
        int last, outs, accs, gap_bad, rdy_bad;
        last = 0; outs = 0; accs = 0; gap_bad = 0; rdy_bad = 0;
        @(negedge clk);
        sig_in_v[0] = 16'sd0; en_v[0] = 1'b1;
        for (int t = 0; t < 45; t++) begin
            if (rdy_w[0]) accs++;
            if (rdy_w[0] !== (t % 10 == 0)) rdy_bad++;
            if (eo_w[0]) begin
                outs++;
                if (t - last != 10 || out_w[0] !== 16'sd0) gap_bad++;
                last = t;
            end
            @(negedge clk);
        end
        en_v[0] = 1'b0;
        checks++;
        if (accs !== 5 || outs !== 4 || gap_bad !== 0 || rdy_bad !== 0) begin
            failures++;
            $display("FAIL held_en accepts=%0d outs=%0d gap_err=%0d rdy_err=%0d want 5/4/0/0", accs, outs, gap_bad, rdy_bad);
        end
        run_sample(0, 16'sd0, 3, 3'd0, 16'sd5, y, lat, rb);
        checks++;
        if (y !== 16'sd0) begin failures++; $display("FAIL coef_in_mac_sample y=%0d want 0", y); end
        run_sample(0, 16'sd1, -1, 3'd0, 16'sd0, y, lat, rb);
        checks++;
        if (y !== 16'sd1) begin failures++; $display("FAIL coef_dropped y=%0d want 1", y); end
        run_sample(0, 16'sd0, 0, 3'd1, 16'sd9, y, lat, rb);
        checks++;
        if (y !== 16'sd9) begin failures++; $display("FAIL coef_same_cycle y=%0d want 9", y); end
    endtask

    task automatic test_saturation();
        logic signed [15:0] y, e; int lat, rb;
        for (int k = 0; k < 8; k++) write_coef(0, 3'(k), 16'sh7FFF);
        for (int i = 0; i < 8; i++) begin
            run_sample(0, 16'sh7FFF, -1, 3'd0, 16'sd0, y, lat, rb);
            checks++;
            if (y !== 16'sh7FFF) begin failures++; $display("FAIL sat_pos[%0d] y=%h want 7fff", i, y); end
        end
        for (int i = 0; i < 8; i++) begin
            run_sample(0, 16'sh8000, -1, 3'd0, 16'sd0, y, lat, rb);
            e = i < 3 ? 16'sh7FFF : 16'sh8000;
            checks++;
            if (y !== e) begin failures++; $display("FAIL sat_neg[%0d] y=%h want %h", i, y, e); end
        end
    endtask

    task automatic test_rounding();
        logic signed [15:0] y; int lat, rb;
        logic signed [15:0] vin [4];
        logic signed [15:0] exp_y [4];
        vin = '{16'sd3, -16'sd3, 16'sd1, -16'sd1};
        exp_y = '{16'sd2, -16'sd1, 16'sd1, 16'sd0};
        write_coef(1, 3'd0, 16'sh4000);
        for (int i = 0; i < 4; i++) begin
            run_sample(1, vin[i], -1, 3'd0, 16'sd0, y, lat, rb);
            checks++;
            if (y !== exp_y[i]) begin failures++; $display("FAIL round[%0d] in=%0d y=%0d want %0d", i, vin[i], y, exp_y[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic signed [15:0] y; int lat, rb, strobes;
        @(negedge clk);
        sig_in_v[0] = 16'sd5; en_v[0] = 1'b1;
        @(negedge clk);
        en_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_w[0] !== 16'sd0 || eo_w[0] !== 1'b0 || rdy_w[0] !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid sig_out=%0d en_out=%b rdy_in=%b want 0/0/1", out_w[0], eo_w[0], rdy_w[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        strobes = 0;
        repeat (12) begin @(negedge clk); if (eo_w[0]) strobes++; end
        checks++;
        if (strobes !== 0) begin failures++; $display("FAIL reset_discard en_out_count=%0d want 0", strobes); end
        for (int k = 0; k < 8; k++) write_coef(0, 3'(k), 16'(k + 1));
        for (int i = 0; i < 3; i++) begin
            run_sample(0, i == 0 ? 16'sd1 : 16'sd0, -1, 3'd0, 16'sd0, y, lat, rb);
            checks++;
            if (y !== 16'(i + 1) || lat !== 10) begin
                failures++;
                $display("FAIL post_reset[%0d] y=%0d lat=%0d want y=%0d lat=10", i, y, lat, i + 1);
            end
        end
    endtask

    task automatic test_addr_range();
        logic signed [15:0] y, e; int lat, rb;
        for (int k = 0; k < 6; k++) write_coef(2, 3'(k), 16'(10 * (k + 1)));
        write_coef(2, 3'd6, 16'sd77);
        write_coef(2, 3'd7, 16'sd99);
        for (int i = 0; i < 7; i++) begin
            run_sample(2, i == 0 ? 16'sd1 : 16'sd0, -1, 3'd0, 16'sd0, y, lat, rb);
            e = i < 6 ? 16'(10 * (i + 1)) : 16'sd0;
            checks++;
            if (y !== e || lat !== 8) begin
                failures++;
                $display("FAIL addr_range[%0d] y=%0d lat=%0d want y=%0d lat=8", i, y, lat, e);
            end
        end
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            sig_in_v[s] = '0; en_v[s] = 1'b0; we_v[s] = 1'b0; addr_v[s] = '0; data_v[s] = '0;
        end
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_impulse();
        test_handshake();
        test_saturation();
        test_rounding();
        test_reset_mid();
        test_addr_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
